// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Op codes, FSM encoding and helpers for the RV32M mul/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // pos 0 = rs1, pos 1 = rs2; any other position is never treated as signed
    function automatic logic op_signed(input logic [2:0] op, input int pos);
        case (pos)
            0:       return (op != F3_MULHU) && (op != F3_DIVU) && (op != F3_REMU);
            1:       return (op == F3_MUL) || (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_signfix.sv
// ============================================================================
// Module      : muldiv_signfix
// Description : Magnitude / negate stage for one operand position or result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int W   = 32,
    parameter int POS = 0
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] din,
    input  logic         neg_req,
    output logic [W-1:0] dout
);

    logic w_neg;

    assign w_neg = neg_req | (op_signed(op, POS) & din[W-1]);
    assign dout  = w_neg ? -din : din;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit with valid/ready and kill.
//               Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    state_t              r_state, w_state_next;
    logic [2:0]          r_op;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opb;
    logic [XLEN:0]       r_rem;
    logic                r_sa, r_sb;
    logic [XLEN-1:0]     r_result;

    logic [XLEN-1:0]     w_mag_a, w_mag_b;
    logic                w_sa, w_sb, w_ovf, w_accept;
    logic                w_short;
    logic [XLEN-1:0]     w_short_res;
    logic [XLEN:0]       w_madd;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN+1:0]     w_trial, w_diff;
    logic                w_ge;
    logic [XLEN:0]       w_rem_next;
    logic [XLEN-1:0]     w_quo_next;
    logic [2*XLEN-1:0]   w_res_in, w_res_fix;
    logic                w_res_neg;
    logic [XLEN-1:0]     w_res_final;

    muldiv_signfix #(.W(XLEN), .POS(0)) u_fix_a (
        .op(op), .din(rs1), .neg_req(1'b0), .dout(w_mag_a)
    );
    muldiv_signfix #(.W(XLEN), .POS(1)) u_fix_b (
        .op(op), .din(rs2), .neg_req(1'b0), .dout(w_mag_b)
    );

    assign w_sa     = op_signed(op, 0) & rs1[XLEN-1];
    assign w_sb     = op_signed(op, 1) & rs2[XLEN-1];
    assign w_ovf    = op_signed(op, 0) & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2);
    assign w_accept = in_valid & (r_state == IDLE) & ~kill;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fa, w_fb, w_fprod;
    assign w_fa    = {{XLEN{op_signed(op, 0) & rs1[XLEN-1]}}, rs1};
    assign w_fb    = {{XLEN{op_signed(op, 1) & rs2[XLEN-1]}}, rs2};
    assign w_fprod = w_fa * w_fb;
`endif

    // Cases resolved at acceptance and skipping RUN entirely
    always_comb begin
        w_short     = 1'b0;
        w_short_res = '0;
        if (is_div(op)) begin
            if (rs2 == '0) begin
                w_short     = 1'b1;
                w_short_res = op[1] ? rs1 : '1;
            end else if (w_ovf) begin
                w_short     = 1'b1;
                w_short_res = op[1] ? '0 : rs1;
            end
        end else if ((rs1 == '0) || (rs2 == '0)) begin
            w_short = 1'b1;
        end
`ifdef MULDIV_FAST_MUL_EN
        else begin
            w_short     = 1'b1;
            w_short_res = (op == F3_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
        end
`endif
    end

    // Shift-add: multiplier sits in the low half and drains out to the right
    assign w_madd     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_next = {w_madd, r_acc[XLEN-1:1]};

    // Restoring divide: dividend shifts out of the low half, quotient shifts in
    assign w_trial    = {r_rem, r_acc[XLEN-1]};
    assign w_diff     = w_trial - {2'b00, r_opb};
    assign w_ge       = ~w_diff[XLEN+1];
    assign w_rem_next = w_ge ? w_diff[XLEN:0] : w_trial[XLEN:0];
    assign w_quo_next = {r_acc[XLEN-2:0], w_ge};

    always_comb begin
        w_res_in  = w_mul_next;
        w_res_neg = r_sa ^ r_sb;
        if (is_div(r_op)) begin
            if (r_op[1]) begin
                w_res_in  = {{XLEN{1'b0}}, w_rem_next[XLEN-1:0]};
                w_res_neg = r_sa;
            end else begin
                w_res_in  = {{XLEN{1'b0}}, w_quo_next};
            end
        end
    end

    muldiv_signfix #(.W(2*XLEN), .POS(2)) u_fix_res (
        .op(r_op), .din(w_res_in), .neg_req(w_res_neg), .dout(w_res_fix)
    );

    assign w_res_final = ((r_op == F3_MUL) || is_div(r_op)) ? w_res_fix[XLEN-1:0]
                                                            : w_res_fix[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (kill) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (in_valid) w_state_next = w_short ? DONE : RUN;
                RUN:     if (r_cnt == CNT_W'(1)) w_state_next = DONE;
                DONE:    if (out_ready) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_rem    <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= op;
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_cnt <= CNT_W'(XLEN);
            r_acc <= {{XLEN{1'b0}}, w_mag_a};
            r_opb <= w_mag_b;
            r_rem <= '0;
            if (w_short) r_result <= w_short_res;
        end else if ((r_state == RUN) && !kill) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_acc <= is_div(r_op) ? {r_acc[2*XLEN-1:XLEN], w_quo_next} : w_mul_next;
            if (is_div(r_op)) r_rem <= w_rem_next;
            if (r_cnt == CNT_W'(1)) r_result <= w_res_final;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign result    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit (XLEN=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN     = 32;
    localparam int ITER_LAT = XLEN + 1;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
`else
    localparam int MUL_LAT  = ITER_LAT;
`endif

    logic            clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, kill = 1'b0, out_ready = 1'b0;
    logic [2:0]      op = '0;
    logic [XLEN-1:0] rs1 = '0, rs2 = '0;
    logic            in_ready, out_valid, busy;
    logic [XLEN-1:0] result;
    int              n_vec = 0, n_miss = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1(rs1), .rs2(rs2), .kill(kill), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        case (o)
            F3_MUL:    begin p = sa * sb; return p[31:0];  end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = longint'($signed(b[31:0]) * 0) + sa * longint'({32'b0, b}); return p[63:32]; end
            F3_MULHU:  begin p = ua * longint'({32'b0, b}); return p[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                p = sa / sb; return p[31:0];
            end
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            F3_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2]) begin
            if (b == 0) return 1;
            if ((o == F3_DIV || o == F3_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
            return ITER_LAT;
        end
        if (a == 0 || b == 0) return 1;
        return MUL_LAT;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, scramble inputs after acceptance, wait for result, then retire it
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; op = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        if (!out_valid) kill = 1'b1;
        else            out_ready = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res, a, b;
        logic [2:0]  o;
        int          lat;
        bit          seen;

        tbl[0]  = '{F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
        tbl[1]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
        tbl[2]  = '{F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT};
        tbl[3]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT};
        tbl[4]  = '{F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, ITER_LAT};
        tbl[5]  = '{F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, ITER_LAT};
        tbl[6]  = '{F3_DIVU,   32'd100,      32'd7,        32'd14,       ITER_LAT};
        tbl[7]  = '{F3_REMU,   32'd100,      32'd7,        32'd2,        ITER_LAT};
        tbl[8]  = '{F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
        tbl[9]  = '{F3_REM,    32'd5,        32'd0,        32'd5,        1};
        tbl[10] = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        tbl[11] = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        tbl[12] = '{F3_DIVU,   32'd9,        32'd0,        32'hFFFFFFFF, 1};
        tbl[13] = '{F3_REMU,   32'd9,        32'd0,        32'd9,        1};
        tbl[14] = '{F3_MULH,   32'd0,        32'h12345678, 32'd0,        1};
        tbl[15] = '{F3_MUL,    32'h00012345, 32'h00010000, 32'h23450000, MUL_LAT};

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_result",    result,         32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].o, tbl[i].a, tbl[i].b, res, lat);
            check($sformatf("tbl%0d_result", i), res, tbl[i].exp);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
        end

        for (int i = 0; i < 150; i++) begin
            o = 3'($urandom);
            a = pick();
            b = pick();
            run_op(o, a, b, res, lat);
            check($sformatf("rnd%0d_op%0d_result", i, o), res, ref_op(o, a, b));
            check($sformatf("rnd%0d_op%0d_latency", i, o), 32'(lat), 32'(exp_lat(o, a, b)));
        end

        // Backpressure in DONE, then immediate accept after retirement
        op = F3_MULHU; rs1 = 32'hDEADBEEF; rs2 = 32'h12345678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check("bp_reach_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_result_hold", result, ref_op(F3_MULHU, 32'hDEADBEEF, 32'h12345678));
            check("bp_out_valid_hold", 32'(out_valid), 32'd1);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_back_idle", 32'(in_ready), 32'd1);
        check("bp_out_valid_drop", 32'(out_valid), 32'd0);
        op = F3_DIVU; rs1 = 32'd1000; rs2 = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_accept_busy", 32'(busy), 32'd1);

        // Kill at RUN cycle 10
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_in_ready", 32'(in_ready), 32'd1);
        check("kill_busy", 32'(busy), 32'd0);
        check("kill_out_valid", 32'(out_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check("kill_no_result", 32'(seen), 32'd0);

        // Kill together with in_valid in IDLE must not accept
        op = F3_DIV; rs1 = 32'd5; rs2 = 32'd0; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        check("kill_idle_no_accept", 32'(busy), 32'd0);

        // Kill with out_ready in DONE
        op = F3_DIV; rs1 = 32'd5; rs2 = 32'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("killdone_out_valid", 32'(out_valid), 32'd1);
        kill = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; out_ready = 1'b0;
        check("killdone_idle", 32'(in_ready), 32'd1);

        // Asynchronous reset mid-RUN
        op = F3_MUL; rs1 = 32'd7; rs2 = 32'hFFFFFFFD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_result", result, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(F3_REM, 32'hFFFFFF9C, 32'd7, res, lat);
        check("post_rst_rem", res, 32'hFFFFFFFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, parametrised in XLEN.
- Sits in EX beside the ALU. The ALU control unit routes funct7=0000001 R-type ops here instead of decoding them to combinational ALU selects.
- Multi-cycle; stalls the pipeline through a valid/ready handshake on both input and output.
- Supports a flush (kill) mid-operation.

Parameters:
- XLEN, 32, operand/result width; must be even and ≥ 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request from EX
- in_ready  out  1  unit can accept; high only in IDLE
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  XLEN  operand a
- rs2  in  XLEN  operand b
- kill  in  1  pipeline flush; abandon current operation
- out_valid  out  1  result available; high only in DONE
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result, stable while out_valid
- busy  out  1  high in RUN or DONE; used as hazard stall

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, result=0.
  - All internal registers are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - Acceptance occurs on in_valid & in_ready & !kill at a rising edge.
  - Operands and op are latched at that edge.
  - Signed ops (MUL, MULH, DIV, REM) and MULHSU's rs1 are converted to magnitudes; sign flags are stored.
  - Counter is loaded with XLEN.
  - Next state is RUN, or DONE for the special cases below.
- RUN (multiply):
  - One shift-add step per cycle on magnitudes.
  - Accumulator is 2*XLEN wide.
- RUN (divide):
  - One restoring step per cycle on magnitudes.
  - Remainder register is XLEN+1 wide.
- RUN exit:
  - Counter decrements each cycle; at 0 the state moves to DONE.
  - Sign correction is applied in the same transition.
  - Normal latency: acceptance edge + XLEN RUN edges, so out_valid rises XLEN+1 cycles after acceptance.
- Sign rules:
  - Product negated if sa^sb.
  - Quotient negated if sa^sb.
  - Remainder takes the dividend's sign (sa).
- Result selection:
  - MUL: low XLEN of product.
  - MULH/MULHSU/MULHU: high XLEN of product.
- Special cases (decided at acceptance, go straight to DONE, latency 1):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): DIV → rs1; REM → 0.
  - MUL/MULH* with either operand 0 → 0.
- DONE:
  - out_valid=1; result is held constant.
  - On out_valid & out_ready, the next state is IDLE.
  - in_ready stays 0 until IDLE; there is no back-to-back accept in the same cycle.
- kill:
  - In any state, moves to IDLE at the next edge.
  - out_valid drops at that edge; the partial result is discarded.
  - kill in the same cycle as in_valid in IDLE: no acceptance.
  - kill in DONE together with out_ready: treated as a kill; the consumer must ignore the result.
- rst_n low mid-operation: immediate IDLE and reset values, with no result produced.
- in_valid is don't-care outside IDLE; rs1/rs2/op are ignored after acceptance.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU compute a single-cycle (XLEN+1)x(XLEN+1) signed product at acceptance and go straight to DONE (latency 1).
  - Divides remain iterative.
- Undefined: all multiplies are iterative as above, with no wide multiplier inferred.
- Results must be bit-identical in both builds.

Decomposition:
- muldiv_pkg holds:
  - op codes F3_MUL..F3_REMU, shared with the ALU control unit's F3 defines.
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Helper function is_div(op).
- One sub-module, muldiv_signfix: combinational magnitude/negate for a given op and operand position. Instantiated once per input operand and once per output.

Test Plan:
- MUL rs1=7, rs2=-3 (XLEN=32) → result 0xFFFFFFEB; out_valid exactly 33 cycles after acceptance.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU -1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV x/0 with x=5 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/-1 → 0x80000000; REM → 0. All with latency 1.
- out_ready held low 5 cycles in DONE → result and out_valid stable, in_ready=0. Then out_ready=1 → IDLE, and a new op is accepted the following cycle.
- kill asserted at RUN cycle 10 → IDLE next edge, out_valid never rises, busy=0. rst_n pulsed low mid-RUN → all outputs at reset values immediately.
